// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
// Bundles the three buses around the data-memory controller:
//   - MEM-stage request bus (cpu_*): request, qualifiers, load result, status
//   - loader byte-write bus (ldr_*): preload port, lower priority than the CPU
//   - RAM bus (mem_*): byte-wide synchronous RAM, 1-cycle read latency
// Modports:
//   slave  : the controller view (consumes requests, drives the RAM)
//   master : the environment view (pipeline, loader and RAM together)
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if #(
   parameter int N          = 32,
   parameter int ADDR_WIDTH = 12
);
   // MEM-stage bus
   logic                  cpu_req;
   logic                  cpu_we;
   logic                  cpu_isByte;
   logic [N-1:0]          cpu_addr;
   logic [N-1:0]          cpu_wdata;
   logic [N-1:0]          cpu_rdata;
   logic                  cpu_done;
   logic                  cpu_err;
   logic                  cpu_stall;

   // loader bus
   logic                  ldr_req;
   logic [ADDR_WIDTH-1:0] ldr_addr;
   logic [7:0]            ldr_wdata;
   logic                  ldr_ack;

   // RAM bus
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wdata;
   logic                  mem_we;
   logic                  mem_re;
   logic [7:0]            mem_rdata;

   modport slave (
      input  cpu_req, cpu_we, cpu_isByte, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_done, cpu_err, cpu_stall,
      input  ldr_req, ldr_addr, ldr_wdata,
      output ldr_ack,
      output mem_addr, mem_wdata, mem_we, mem_re,
      input  mem_rdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_isByte, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_done, cpu_err, cpu_stall,
      output ldr_req, ldr_addr, ldr_wdata,
      input  ldr_ack,
      input  mem_addr, mem_wdata, mem_we, mem_re,
      output mem_rdata
   );
endinterface : data_mem_ctrl_if

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Sequencer/arbiter for the byte-wide data memory. Splits 32-bit word and byte
// loads/stores from the MEM stage into single-byte RAM cycles (little-endian),
// stalls the pipeline until the access completes, and lets a byte-wide loader
// write the RAM whenever the CPU is not requesting.
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : data_mem_ctrl_if.slave
//            cpu_* request/qualifiers in, cpu_rdata/done/err/stall out
//            ldr_* byte-write request in, ldr_ack out
//            mem_* address/write data/strobes out, mem_rdata in
// Latency (request sampled in IDLE -> cpu_done cycle):
//   word load 6, byte load 3, word store 5, byte store 2, misaligned word 1
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
   parameter int N          = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   data_mem_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_TAIL,
      WR,
      LDR,
      DONE
   } state_t;

   state_t                r_state;
   state_t                w_next;

   // access context latched when a request is accepted in IDLE
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_k;
   logic [1:0]            r_last;
   logic                  r_is_byte;
   logic                  r_err;
   logic [N-1:0]          r_wdata;

   // read return tracking: a byte issued in RD arrives one cycle later
   logic                  r_rd_pend;
   logic [1:0]            r_rd_lane;
   logic [N-1:0]          r_shadow;
   logic [N-1:0]          r_cpu_rdata;

   logic                  w_misaligned;
   logic [4:0]            w_byte_sel;
   logic [4:0]            w_lane_sel;
   logic [N-1:0]          w_shadow_merged;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [7:0]            w_mem_wdata;
   logic                  w_mem_we;
   logic                  w_mem_re;
   logic                  w_ldr_ack;
   logic                  w_cpu_done;
   logic                  w_cpu_err;
   logic                  w_unused_addr;

   // address bits above the RAM depth are ignored
   assign w_unused_addr = ^bus.cpu_addr[N-1:ADDR_WIDTH];

   assign w_misaligned = ~bus.cpu_isByte & (bus.cpu_addr[1:0] != 2'b00);
   assign w_byte_sel   = {r_k, 3'b000};
   assign w_lane_sel   = {r_rd_lane, 3'b000};

   // Shadow with the byte arriving this cycle already merged in, so the final
   // byte captured in RD_TAIL reaches cpu_rdata together with the DONE state.
   always_comb begin
      w_shadow_merged = r_shadow;
      if (r_rd_pend) begin
         w_shadow_merged[w_lane_sel +: DATA_WIDTH] = bus.mem_rdata;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------------
   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state and memory/handshake outputs
   // ---------------------------------------------------------------------------
   // NOTE: every output of this block is given a default first so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_next      = r_state;
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      w_mem_we    = 1'b0;
      w_mem_re    = 1'b0;
      w_ldr_ack   = 1'b0;
      w_cpu_done  = 1'b0;
      w_cpu_err   = 1'b0;

      unique case (r_state)
         IDLE: begin
            // CPU wins over the loader
            if (bus.cpu_req) begin
               if (w_misaligned) begin
                  w_next = DONE;
               end else if (bus.cpu_we) begin
                  w_next = WR;
               end else begin
                  w_next = RD;
               end
            end else if (bus.ldr_req) begin
               w_next = LDR;
            end
         end

         RD: begin
            w_mem_re   = 1'b1;
            w_mem_addr = r_addr + ADDR_WIDTH'(r_k);
            if (r_k == r_last) begin
               w_next = RD_TAIL;
            end
         end

         RD_TAIL: begin
            w_next = DONE;
         end

         WR: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_addr + ADDR_WIDTH'(r_k);
            w_mem_wdata = r_wdata[w_byte_sel +: DATA_WIDTH];
            if (r_k == r_last) begin
               w_next = DONE;
            end
         end

         LDR: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = bus.ldr_addr;
            w_mem_wdata = bus.ldr_wdata;
            w_ldr_ack   = 1'b1;
            w_next      = IDLE;
         end

         DONE: begin
            w_cpu_done = 1'b1;
            w_cpu_err  = r_err;
            w_next     = IDLE;
         end

         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Access context and byte counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr    <= '0;
         r_k       <= '0;
         r_last    <= '0;
         r_is_byte <= 1'b0;
         r_err     <= 1'b0;
         r_wdata   <= '0;
      end else begin
         if (r_state == IDLE && bus.cpu_req) begin
            r_addr    <= bus.cpu_addr[ADDR_WIDTH-1:0];
            r_k       <= 2'd0;
            r_last    <= bus.cpu_isByte ? 2'd0 : 2'd3;
            r_is_byte <= bus.cpu_isByte;
            r_err     <= w_misaligned;
            r_wdata   <= bus.cpu_wdata;
         end else if (r_state == RD || r_state == WR) begin
            r_k <= r_k + 2'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read data capture and load result
   // ---------------------------------------------------------------------------
   // NOTE: the shadow is a single word register, not a memory array, so it is
   // reset along with the rest of the datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_pend   <= 1'b0;
         r_rd_lane   <= '0;
         r_shadow    <= '0;
         r_cpu_rdata <= '0;
      end else begin
         r_rd_pend <= (r_state == RD);
         r_rd_lane <= r_k;
         if (r_rd_pend) begin
            r_shadow <= w_shadow_merged;
         end
         // only loads pass through RD_TAIL, so cpu_rdata changes exactly when a
         // successful load enters DONE and holds otherwise
         if (r_state == RD_TAIL) begin
            if (r_is_byte) begin
               r_cpu_rdata <= {{(N-DATA_WIDTH){1'b0}}, w_shadow_merged[DATA_WIDTH-1:0]};
            end else begin
               r_cpu_rdata <= w_shadow_merged;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Output drive
   // ---------------------------------------------------------------------------
   assign bus.mem_addr  = w_mem_addr;
   assign bus.mem_wdata = w_mem_wdata;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_re    = w_mem_re;
   assign bus.ldr_ack   = w_ldr_ack;
   assign bus.cpu_done  = w_cpu_done;
   assign bus.cpu_err   = w_cpu_err;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.cpu_stall = bus.cpu_req & ~w_cpu_done;

endmodule : data_mem_ctrl

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Sequencer and arbiter for the byte-wide data memory of the pipeline. It breaks 32-bit word and byte load/store requests from the MEM stage into single-byte memory cycles, and stalls the pipeline until the access completes. It also shares the memory with a byte-wide loader port that is used to preload image and data contents. It sits between the MEM stage and a byte-wide synchronous RAM with a 1-cycle read latency.

Parameters:
N, 32, CPU address and data width
ADDR_WIDTH, 12, memory byte-address width; depth is 2^ADDR_WIDTH bytes
DATA_WIDTH, 8, memory word width; fixed at one byte

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  reset, asynchronous, active-low
cpu_req  in  1  MEM-stage access request; held with its qualifiers until cpu_done
cpu_we  in  1  1 = store, 0 = load
cpu_isByte  in  1  1 = byte access, 0 = word access
cpu_addr  in  N  byte address; bits above ADDR_WIDTH-1 are ignored
cpu_wdata  in  N  store data; a byte store uses bits [7:0]
cpu_rdata  out  N  load result
cpu_done  out  1  one-cycle completion pulse
cpu_err  out  1  one-cycle pulse, coincident with cpu_done, for a misaligned word access
cpu_stall  out  1  pipeline stall
ldr_req  in  1  loader byte-write request
ldr_addr  in  ADDR_WIDTH  loader byte address
ldr_wdata  in  8  loader byte
ldr_ack  out  1  one-cycle pulse; the loader byte is written this cycle
mem_addr  out  ADDR_WIDTH  RAM byte address
mem_wdata  out  8  RAM write byte
mem_we  out  1  RAM write strobe
mem_re  out  1  RAM read strobe
mem_rdata  in  8  RAM read byte; valid the cycle after mem_re

Behaviour:
- Reset (asynchronous, rst_n=0): FSM goes to IDLE. cpu_rdata=0, cpu_done=0, cpu_err=0, ldr_ack=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0.
- Reset mid-operation: the access is abandoned. Bytes already written stay in RAM. No done pulse is generated.
- cpu_stall = cpu_req & ~cpu_done (combinational). cpu_stall is 0 when cpu_req is 0.
- Byte order: little-endian. Byte k of a word is at address (a+k) mod 2^ADDR_WIDTH, for k = 0..3.
- FSM states: IDLE, RD, RD_TAIL, WR, LDR, DONE.
- IDLE:
  - cpu_req has priority over ldr_req.
  - cpu_req with cpu_isByte=0 and cpu_addr[1:0]≠0 goes to DONE with cpu_err=1. No memory access occurs and cpu_rdata is unchanged.
  - Otherwise cpu_req goes to RD or WR with byte counter k=0 and last = (isByte ? 0 : 3).
  - ldr_req with no cpu_req goes to LDR.
- RD:
  - Each cycle: mem_re=1, mem_addr = a+k.
  - Increment k; after k = last, go to RD_TAIL.
  - Each returned byte is captured one cycle after its issue into lane k of a shadow register.
- RD_TAIL: captures the final byte, then goes to DONE.
- WR:
  - Each cycle: mem_we=1, mem_addr = a+k, mem_wdata = cpu_wdata[8k+7:8k].
  - After k = last, go to DONE.
- LDR (1 cycle): mem_we=1, mem_addr=ldr_addr, mem_wdata=ldr_wdata, ldr_ack=1. Returns to IDLE.
- DONE (1 cycle): cpu_done=1. On a load, cpu_rdata is updated from the shadow register; a byte load is zero-extended to N bits. Returns to IDLE.
- cpu_rdata holds its value until the next successful load completes.
- Latency from the cycle cpu_req is sampled in IDLE to the cpu_done cycle:
  - word load: 6
  - byte load: 3
  - word store: 5
  - byte store: 2
  - misaligned word: 1
- Back-to-back accesses: there is at least one IDLE cycle after DONE. A cpu_req still high in that IDLE cycle is treated as a new access.
- Loader: it is served only in IDLE cycles with cpu_req=0. ldr_req must stay high until ldr_ack. Consecutive loader bytes each take 2 cycles (LDR then IDLE).
- Simultaneous cpu_req and ldr_req in IDLE: CPU is served; the loader waits.
- mem_we and mem_re are never both 1. At most one memory strobe is active per cycle.
- Address wrap: byte addresses wrap modulo 2^ADDR_WIDTH. An aligned word never wraps within itself.
- Changing request inputs mid-access is illegal. The bench asserts this.

Test Plan:
- Word store then load: store cpu_addr=0x010, wdata=0xDEADBEEF, then load 0x010 -> bytes EF,BE,AD,DE written to 0x010..0x013; load returns 0xDEADBEEF; done at latency 5 and 6; stall high until done.
- Byte access: byte store 0xA5 to 0x013 over the word above, then byte load 0x013 -> cpu_rdata=0x000000A5; word load 0x010 -> 0xA5ADBEEF.
- Misaligned word: load at 0x012 -> cpu_done and cpu_err pulse 1 cycle after request; no mem_re or mem_we; cpu_rdata unchanged.
- Arbitration: ldr_req (addr 0x020, 0x5A) and cpu word load both raised in IDLE -> CPU served first; ldr_ack only after CPU DONE plus IDLE with cpu_req low; RAM[0x020]=0x5A.
- Reset mid-op: assert rst_n=0 during the third byte of a word store to 0x030 -> outputs 0 immediately; RAM[0x030..0x031] written, 0x032..0x033 untouched; no cpu_done; next access works normally.
- Wrap and high bits: cpu_addr=0xFFFF_FFFC word store 0x11223344 (ADDR_WIDTH=12) -> RAM[0xFFC..0xFFF]=44,33,22,11; load back returns 0x11223344.
